sp_ram_req_adapter: RTL and testbench
=====================================

Name: sp_ram_req_adapter

Overview:
- Initiator-side adapter between a core/bus data port (req/gnt/rvalid, byte addressing, sub-word sizes) and one 32-bit single-port RAM with byte enables and 1-cycle read latency.
- Converts byte address plus size into a word address, byte enables and lane-shifted write data.
- Aligns, masks and sign/zero-extends read data.
- Splits word/halfword accesses that cross a word boundary into two RAM cycles.

Parameters:
ADDR_WIDTH, 8, RAM word-address width; byte address is ADDR_WIDTH+2 bits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
req_i  in  1  request valid
gnt_o  out  1  request accepted this cycle
addr_i  in  ADDR_WIDTH+2  byte address
we_i  in  1  1=write, 0=read
size_i  in  2  0=byte, 1=half, 2=word, 3=treated as word
sext_i  in  1  sign-extend read result
wdata_i  in  32  write data, LSB-aligned
rvalid_o  out  1  response valid, one per granted request
rdata_o  out  32  read result; 0 for writes
err_o  out  1  error, valid with rvalid_o
ram_en_o  out  ADDR-independent 1  RAM enable
ram_addr_o  out  ADDR_WIDTH  RAM word address
ram_we_o  out  1  RAM write enable
ram_be_o  out  4  RAM byte enables
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data, valid 1 cycle after address

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low. All state is sampled on the rising edge.
- Reset values: state=IDLE, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, ram_en_o=0, ram_we_o=0, ram_be_o=0. Reset mid-split abandons the second access and no rvalid is produced.
- States: IDLE, SECOND.
- In IDLE:
  - gnt_o = req_i (combinational); a grant in cycle T is an acceptance.
  - Grant cycle drives ram_en_o=1, ram_addr_o=addr_i[ADDR_WIDTH+1:2], ram_we_o=we_i.
- Lane computation:
  - off = addr_i[1:0]; mask = 1/3/F for byte/half/word.
  - be64 = mask << off (8 bits); wd64 = wdata_i << (8*off) (64 bits).
  - First access: ram_be_o = be64[3:0], ram_wdata_o = wd64[31:0].
- Misaligned access: be64[7:4] != 0, i.e. half at off=3, or word at off 1..3.
  - IDLE -> SECOND.
  - In T+1: gnt_o=0; RAM access at word address +1, modulo 2^ADDR_WIDTH (wraps max -> 0), with be64[7:4] and wd64[63:32].
  - SECOND -> IDLE unconditionally.
- Aligned access stays in IDLE, giving back-to-back throughput of 1 request/cycle.
- Response pipeline: registers off, size, sext, we and split flag at grant.
  - Aligned: rvalid_o in T+1; rdata from ram_rdata_i >> 8*off.
  - Split: first-word ram_rdata_i is captured in T+1; rvalid_o in T+2 with data = ({second,first} >> 8*off)[31:0].
- Result formatting: bits above the size are masked. If sext_i, they are filled from bit 7 (byte) or bit 15 (half); otherwise zeros.
- Writes: rvalid_o asserted with the same latency; rdata_o = 0.
- Exclusivity: responses never overlap. rvalid_o is a single-cycle pulse per request, in order.
- Outside the grant and second-access cycles: ram_en_o=0, ram_we_o=0, ram_be_o=0.

Optional Feature:
SP_RAM_REQ_ADAPTER_SPLIT_EN
- Defined: misaligned accesses are split as above; err_o is always 0.
- Undefined: misaligned requests are still granted, but no RAM access is issued (ram_en_o=0, ram_we_o=0, memory unchanged). rvalid_o asserts in T+1 with err_o=1 and rdata_o=0. State never leaves IDLE.
- Aligned behaviour is identical in both builds.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x10, lw -> RAM addr 4, be=F; read rvalid 1 cycle after grant, rdata=0xDEADBEEF.
- Byte read @0x11 with sext=1, then sext=0 (mem word 0x0080FF00) -> 0xFFFFFFFF, then 0x000000FF.
- Halfword write 0xA55A @0x13 (SPLIT_EN):
  - RAM cycles: addr 4 be=8 wdata[31:24]=0x5A; addr 5 be=1 wdata[7:0]=0xA5.
  - gnt low in T+1; rvalid in T+2.
  - Readback half @0x13 = 0x0000A55A.
- Word read @ byte addr 0x3FE (ADDR_WIDTH=8), mem[255]=0x44332211, mem[0]=0x88776655 -> second access wraps to addr 0; rdata=0x66554433 in T+2.
- Back-to-back aligned reads @0x0,0x4,0x8 with req held -> gnt each cycle; three rvalid pulses in order on consecutive cycles.
- rst_n=0 in T+1 of a split write -> no second RAM write, no rvalid; after release, gnt_o follows req_i in IDLE. Without SPLIT_EN, word read @0x1 -> err_o=1, rdata_o=0, ram_en_o never asserted.

Source files
------------

// File: rtl/sp_ram_req_adapter.sv
// sp_ram_req_adapter
// Bridges a byte-addressed req/gnt/rvalid data port onto one 32-bit
// single-port RAM with byte enables and a 1-cycle read latency.
// Sub-word lanes are placed on the RAM bus, read data is realigned,
// masked and sign/zero-extended, and accesses that straddle a word
// boundary can be split into two RAM cycles.
//
// Build option: define SP_RAM_REQ_ADAPTER_SPLIT_EN to split misaligned
// accesses. Without it, misaligned requests are granted but answered
// with err_o=1 and never reach the RAM.
//
// Handshake: a request is accepted in any cycle where req_i and gnt_o
// are both high; gnt_o is combinational from req_i while idle and low
// during the second half of a split. Every accepted request produces
// exactly one single-cycle rvalid_o pulse, in acceptance order, one
// cycle after acceptance (two for a split). rdata_o/err_o are only
// meaningful while rvalid_o is high and read as zero otherwise.
// dbg_state_o exposes the FSM state (0=IDLE, 1=SECOND).

module sp_ram_req_adapter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH+1:0] addr_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sext_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic                  dbg_state_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t state;

  // Request-side lane computation
  logic [1:0]            off;
  logic [3:0]            mask;
  logic [7:0]            be64;
  logic [63:0]           wd64;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  misaligned;
  logic                  do_split;
  logic                  do_err;
  logic                  grant;

  // State captured at grant for the response and the second access
  logic                  rvalid_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  sext_q;
  logic                  we_q;
  logic                  split_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr2_q;
  logic [3:0]            be2_q;
  logic [31:0]           wd2_q;
  logic [31:0]           first_q;

  // Response formatting
  logic [63:0]           rd64;
  logic [63:0]           rd_shift;
  logic [31:0]           rd_align;
  logic [31:0]           rd_fmt;

  assign off       = addr_i[1:0];
  assign word_addr = addr_i[ADDR_WIDTH+1:2];

  // Byte-enable pattern for the access size, before lane placement
  always_comb begin
    mask = 4'hF;
    case (size_i)
      2'd0:    mask = 4'h1;
      2'd1:    mask = 4'h3;
      default: mask = 4'hF;
    endcase
  end

  // Lanes spill into the upper word when the access crosses a boundary
  assign be64       = {4'b0000, mask} << off;
  assign wd64       = {32'h0, wdata_i} << {off, 3'b000};
  assign misaligned = |be64[7:4];

`ifdef SP_RAM_REQ_ADAPTER_SPLIT_EN
  assign do_split = misaligned;
  assign do_err   = 1'b0;
`else
  assign do_split = 1'b0;
  assign do_err   = misaligned;
`endif

  assign grant       = rst_n && (state == IDLE) && req_i;
  assign gnt_o       = grant;
  assign dbg_state_o = state;

  // RAM command: first access straight from the request, second from registers
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = word_addr;
    ram_wdata_o = wd64[31:0];
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req_i && !do_err) begin
            ram_en_o = 1'b1;
            ram_we_o = we_i;
            ram_be_o = be64[3:0];
          end
        end
        SECOND: begin
          ram_en_o    = 1'b1;
          ram_we_o    = we_q;
          ram_be_o    = be2_q;
          ram_addr_o  = addr2_q;
          ram_wdata_o = wd2_q;
        end
        default: ;
      endcase
    end
  end

  // FSM plus response pipeline: capture request at grant, emit rvalid later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rvalid_q <= 1'b0;
      off_q    <= 2'd0;
      size_q   <= 2'd0;
      sext_q   <= 1'b0;
      we_q     <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      addr2_q  <= '0;
      be2_q    <= 4'h0;
      wd2_q    <= 32'h0;
      first_q  <= 32'h0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            off_q   <= off;
            size_q  <= size_i;
            sext_q  <= sext_i;
            we_q    <= we_i;
            split_q <= do_split;
            err_q   <= do_err;
            // Word address wraps from the top of the RAM back to zero
            addr2_q <= word_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            be2_q   <= be64[7:4];
            wd2_q   <= wd64[63:32];
            if (do_split) begin
              state <= SECOND;
            end else begin
              rvalid_q <= 1'b1;
            end
          end
        end
        SECOND: begin
          // ram_rdata_i holds the first word now; the second arrives next cycle
          first_q  <= ram_rdata_i;
          rvalid_q <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Realign the (possibly two-word) read data to bit 0
  assign rd64     = split_q ? {ram_rdata_i, first_q} : {32'h0, ram_rdata_i};
  assign rd_shift = rd64 >> {off_q, 3'b000};
  assign rd_align = rd_shift[31:0];

  // Mask above the access size and extend from the top bit when requested
  always_comb begin
    rd_fmt = rd_align;
    case (size_q)
      2'd0:    rd_fmt = {{24{sext_q & rd_align[7]}}, rd_align[7:0]};
      2'd1:    rd_fmt = {{16{sext_q & rd_align[15]}}, rd_align[15:0]};
      default: rd_fmt = rd_align;
    endcase
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = rvalid_q & err_q;
  assign rdata_o  = (rvalid_q && !we_q && !err_q) ? rd_fmt : 32'h0;

  // Structural invariants of the handshake and RAM command
  a_no_gnt_in_second: assert property (@(posedge clk) disable iff (!rst_n)
    (state == SECOND) |-> !gnt_o);
  a_err_only_with_valid: assert property (@(posedge clk) disable iff (!rst_n)
    err_o |-> rvalid_o);
  a_ram_quiet_when_off: assert property (@(posedge clk) disable iff (!rst_n)
    !ram_en_o |-> (!ram_we_o && (ram_be_o == 4'h0)));

endmodule

// File: tb/tb_sp_ram_req_adapter.sv
// Bench for sp_ram_req_adapter: directed cases followed by random traffic,
// scored against a byte-array reference memory. Honours
// SP_RAM_REQ_ADAPTER_SPLIT_EN the same way the design does.

module tb_sp_ram_req_adapter;

  localparam int AW     = 8;
  localparam int NWORDS = 1 << AW;
  localparam int NBYTES = 4 * NWORDS;
  localparam int RW     = AW + 37;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_i = 1'b0;
  logic          gnt_o;
  logic [AW+1:0] addr_i = '0;
  logic          we_i = 1'b0;
  logic [1:0]    size_i = 2'd0;
  logic          sext_i = 1'b0;
  logic [31:0]   wdata_i = 32'h0;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic          ram_en_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [3:0]    ram_be_o;
  logic [31:0]   ram_wdata_o;
  logic [31:0]   ram_rdata_i = 32'h0;
  logic          dbg_state_o;

  sp_ram_req_adapter #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .size_i      (size_i),
    .sext_i      (sext_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM behind the adapter ----------------
  logic [31:0] ram_mem [0:NWORDS-1];

  always @(posedge clk) begin
    if (ram_en_o === 1'b1) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
      ram_rdata_i <= ram_mem[ram_addr_o];
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]    ref_mem [0:NBYTES-1];
  logic [32:0]   exp_q[$];
  int            exp_cyc_q[$];
  logic [RW-1:0] ram_q[$];
  int            ram_cyc_q[$];
  int            n_vec = 0;
  int            n_miss = 0;
  int            last_split_cyc = -10;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Byte-level view: list the bytes touched, group them per RAM word,
  // and derive result/err from the byte array. keep_second=0 models an
  // access whose second word never happens and whose response is lost.
  task automatic model_req(input logic [AW+1:0] a, input logic we, input logic [1:0] sz,
                           input logic sx, input logic [31:0] wd, input int g,
                           input bit keep_second, output bit split);
    int          n;
    int          w0;
    int          ba;
    int          k;
    bit          crossing;
    bit          err;
    logic [3:0]  be [2];
    logic [31:0] d [2];
    int          wa [2];
    logic [31:0] res;
    n        = nbytes_of(sz);
    w0       = int'(a) / 4;
    crossing = ((((int'(a) + n - 1) % NBYTES) / 4) != w0);
    err      = 1'b0;
    split    = 1'b0;
`ifdef SP_RAM_REQ_ADAPTER_SPLIT_EN
    split = crossing;
`else
    err = crossing;
`endif
    res   = 32'h0;
    be[0] = 4'h0; be[1] = 4'h0;
    d[0]  = 32'h0; d[1] = 32'h0;
    wa[0] = w0;
    wa[1] = (w0 + 1) % NWORDS;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        ba = (int'(a) + i) % NBYTES;
        k  = (ba / 4 == w0) ? 0 : 1;
        be[k][ba % 4] = 1'b1;
        if (we) d[k][8*(ba % 4) +: 8] = wd[8*i +: 8];
        if (!we) res[8*i +: 8] = ref_mem[ba];
      end
      for (int i = 0; i < n; i++) begin
        ba = (int'(a) + i) % NBYTES;
        k  = (ba / 4 == w0) ? 0 : 1;
        if (we && (k == 0 || keep_second)) ref_mem[ba] = wd[8*i +: 8];
      end
      if (!we && sx && res[8*n-1]) begin
        for (int j = 8*n; j < 32; j++) res[j] = 1'b1;
      end
      for (int kk = 0; kk < (crossing ? 2 : 1); kk++) begin
        if (kk == 0 || keep_second) begin
          ram_q.push_back({wa[kk][AW-1:0], we, be[kk], d[kk]});
          ram_cyc_q.push_back(g + kk);
        end
      end
    end
    if (keep_second) begin
      exp_q.push_back({err, res});
      exp_cyc_q.push_back(g + (split ? 2 : 1));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [AW+1:0] a, input logic we, input logic [1:0] sz,
                        input logic sx, input logic [31:0] wd);
    int  waited;
    bit  split;
    bit  exp_g;
    waited = 0;
    @(posedge clk); #1;
    req_i = 1'b1; addr_i = a; we_i = we; size_i = sz; sext_i = sx; wdata_i = wd;
    #1;
    while (1) begin
      exp_g = (last_split_cyc != cyc - 1);
      chk("gnt", gnt_o, exp_g);
      if (gnt_o === 1'b1) break;
      if (waited >= 4) begin
        n_vec++;
        n_miss++;
        $display("FAIL gnt_timeout: got no grant in %0d cycles, expected a grant", waited);
        return;
      end
      waited++;
      @(posedge clk); #2;
    end
    model_req(a, we, sz, sx, wd, cyc, 1'b1, split);
    if (split) last_split_cyc = cyc;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    req_i = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Reset lands in the second cycle of a split write
  task automatic reset_mid_split();
    bit split;
    @(posedge clk); #1;
    req_i = 1'b1; addr_i = 10'h021; we_i = 1'b1; size_i = 2'd2; sext_i = 1'b0;
    wdata_i = $urandom;
    #1;
    chk("gnt_split_rst", gnt_o, 1'b1);
    model_req(addr_i, 1'b1, 2'd2, 1'b0, wdata_i, cyc, 1'b0, split);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_i = 1'b0;
    #1;
    chk("ram_en_during_rst", ram_en_o, 1'b0);
    chk("ram_we_during_rst", ram_we_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("state_after_rst", dbg_state_o, 1'b0);
    rst_n = 1'b1;
    last_split_cyc = -10;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [32:0]   e;
    int            ec;
    logic [RW-1:0] r;
    int            rc;
    if (rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL rvalid_unexpected: got rvalid at cycle %0d, expected none", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("rdata", rdata_o, e[31:0]);
        chk("err", err_o, e[32]);
        chk("rvalid_cycle", cyc, ec);
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      e  = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL rvalid_missing: got none by cycle %0d, expected rvalid at cycle %0d", cyc, ec);
    end
    if (ram_en_o === 1'b1) begin
      if (ram_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL ram_unexpected: got access addr 0x%0h be 0x%0h, expected none", ram_addr_o, ram_be_o);
      end else begin
        r  = ram_q.pop_front();
        rc = ram_cyc_q.pop_front();
        chk("ram_op", {ram_addr_o, ram_we_o, ram_be_o,
                       ram_we_o ? (ram_wdata_o & lane_mask(ram_be_o)) : 32'h0}, r);
        chk("ram_cycle", cyc, rc);
      end
    end else if (ram_cyc_q.size() > 0 && ram_cyc_q[0] < cyc) begin
      r  = ram_q.pop_front();
      rc = ram_cyc_q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL ram_missing: got none by cycle %0d, expected access 0x%0h at cycle %0d", cyc, r, rc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW+1:0] ra;
    for (int w = 0; w < NWORDS; w++) begin
      ram_mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = ram_mem[w][8*b +: 8];
    end

    // Reset values, with a request pending to show gnt is held off
    rst_n = 1'b0;
    req_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt", gnt_o, 1'b0);
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_ram_en", ram_en_o, 1'b0);
    chk("rst_ram_we", ram_we_o, 1'b0);
    chk("rst_ram_be", ram_be_o, 4'h0);
    chk("rst_state", dbg_state_o, 1'b0);
    req_i = 1'b0;
    rst_n = 1'b1;

    // Word write / read
    do_req(10'h010, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
    do_req(10'h010, 1'b0, 2'd2, 1'b0, 32'h0);
    idle(2);

    // Byte read with and without sign extension
    do_req(10'h010, 1'b1, 2'd2, 1'b0, 32'h0080FF00);
    do_req(10'h011, 1'b0, 2'd0, 1'b1, 32'h0);
    do_req(10'h011, 1'b0, 2'd0, 1'b0, 32'h0);
    do_req(10'h012, 1'b0, 2'd0, 1'b1, 32'h0);
    do_req(10'h012, 1'b0, 2'd1, 1'b1, 32'h0);
    idle(2);

    // Halfword across a word boundary, then readback
    do_req(10'h013, 1'b1, 2'd1, 1'b0, 32'h0000A55A);
    do_req(10'h013, 1'b0, 2'd1, 1'b0, 32'h0);
    do_req(10'h013, 1'b0, 2'd1, 1'b1, 32'h0);
    idle(2);

    // Word read wrapping from the last RAM word to word 0
    do_req(10'h3FC, 1'b1, 2'd2, 1'b0, 32'h44332211);
    do_req(10'h000, 1'b1, 2'd2, 1'b0, 32'h88776655);
    do_req(10'h3FE, 1'b0, 2'd2, 1'b0, 32'h0);
    idle(1);

    // Back-to-back aligned reads with req held
    do_req(10'h000, 1'b0, 2'd2, 1'b0, 32'h0);
    do_req(10'h004, 1'b0, 2'd2, 1'b0, 32'h0);
    do_req(10'h008, 1'b0, 2'd3, 1'b0, 32'h0);
    idle(2);

`ifdef SP_RAM_REQ_ADAPTER_SPLIT_EN
    reset_mid_split();
    do_req(10'h024, 1'b0, 2'd2, 1'b0, 32'h0);
    do_req(10'h020, 1'b0, 2'd2, 1'b0, 32'h0);
    idle(2);
`endif

    // Misaligned word read: split, or error response without RAM access
    do_req(10'h001, 1'b0, 2'd2, 1'b0, 32'h0);
    do_req(10'h001, 1'b1, 2'd2, 1'b0, 32'h12345678);
    do_req(10'h000, 1'b0, 2'd2, 1'b0, 32'h0);
    do_req(10'h004, 1'b0, 2'd2, 1'b0, 32'h0);
    idle(2);

    // Random traffic, biased toward a small window for read-after-write hits
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 1) == 1) ra = 10'($urandom_range(0, 63));
      else ra = 10'($urandom_range(0, NBYTES - 1));
      do_req(ra, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(6);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("ram_q_drained", ram_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
